// File: rtl/fphub_square_if.sv
// Bus between a requester and the FPHUB squarer: operand in, result and status out.
// Handshake: start is sampled only while computing=0; finish is a one-cycle pulse, res/special_case are valid only with it.
interface fphub_square_if #(
   parameter int M = 23,
   parameter int E = 8
);
   localparam int T = M + E;

   logic         start;
   logic [T:0]   x;
   logic [T:0]   res;
   logic         finish;
   logic         computing;
   logic         special_case;

   modport master (
      output start, x,
      input  res, finish, computing, special_case
   );

   modport slave (
      input  start, x,
      output res, finish, computing, special_case
   );
endinterface

// File: rtl/fphub_square.sv
// Multi-cycle FPHUB squarer: radix-2 shift-add of the HUB significand, truncating normalization,
// and a short special path for zero/infinity operands.
module fphub_square #(
   parameter int M = 23,
   parameter int E = 8
) (
   input  logic          clk,
   input  logic          rst_l,
   fphub_square_if.slave bus,
   output logic [1:0]    dbg_state
);
   localparam int T  = M + E;
   localparam int PW = 2*M + 4;
   localparam int SW = M + 2;
   localparam int CW = $clog2(M + 2);
   localparam logic [CW-1:0] CNT_LAST = CW'(M + 1);
   localparam logic [E+2:0]  BIAS     = (E+3)'(2**(E-1) - 1);
   localparam logic [E+2:0]  ER_MAX   = (E+3)'(2**E - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SPECIAL = 2'd1,
      ITER    = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t        state;
   logic [SW-1:0] s_q;
   logic [PW-1:0] mc_q;
   logic [PW-1:0] p_q;
   logic [CW-1:0] cnt_q;
   logic [E-1:0]  exp_q;
   logic          spec_q;
   logic          inf_q;
   logic [T:0]    res_q;
   logic          finish_q;
   logic          computing_q;
   logic          special_q;

   logic [E-1:0]  x_exp;
   logic [M-1:0]  x_man;
   logic          norm_n;
   logic [M-1:0]  man_n;
   logic [E+2:0]  er;
   logic          ovf;
   logic          unf;
   logic [T:0]    res_nxt;
   logic          sc_nxt;

   assign x_exp = bus.x[T-1:M];
   assign x_man = bus.x[M-1:0];

   // er is kept 3 bits wider than the field so 2*exp never wraps; the top bit is its sign.
   always_comb begin
      norm_n  = p_q[PW-1];
      man_n   = norm_n ? p_q[PW-2:M+3] : p_q[PW-3:M+2];
      er      = {2'b00, exp_q, 1'b0} - BIAS + {{(E+2){1'b0}}, norm_n};
      ovf     = !er[E+2] && (er >= ER_MAX);
      unf     = er[E+2] || (er == '0);
      res_nxt = '0;
      sc_nxt  = 1'b0;
      if (spec_q) begin
         res_nxt = inf_q ? {1'b0, {T{1'b1}}} : '0;
         sc_nxt  = 1'b1;
      end else if (ovf) begin
         res_nxt = {1'b0, {T{1'b1}}};
         sc_nxt  = 1'b1;
      end else if (unf) begin
         res_nxt = '0;
         sc_nxt  = 1'b1;
      end else begin
         res_nxt = {1'b0, er[E-1:0], man_n};
      end
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state       <= IDLE;
         s_q         <= '0;
         mc_q        <= '0;
         p_q         <= '0;
         cnt_q       <= '0;
         exp_q       <= '0;
         spec_q      <= 1'b0;
         inf_q       <= 1'b0;
         res_q       <= '0;
         finish_q    <= 1'b0;
         computing_q <= 1'b0;
         special_q   <= 1'b0;
      end else begin
         finish_q  <= 1'b0;
         res_q     <= '0;
         special_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  exp_q       <= x_exp;
                  s_q         <= {1'b1, x_man, 1'b1};
                  mc_q        <= {{(PW-SW){1'b0}}, 1'b1, x_man, 1'b1};
                  p_q         <= '0;
                  cnt_q       <= '0;
                  computing_q <= 1'b1;
                  inf_q       <= &x_exp;
                  if ((x_exp == '0) || (&x_exp)) begin
                     spec_q <= 1'b1;
                     state  <= SPECIAL;
                  end else begin
                     spec_q <= 1'b0;
                     state  <= ITER;
                  end
               end
            end
            SPECIAL: state <= DONE;
            ITER: begin
               // Multiplier bits leave s_q LSB first while the multiplicand walks left.
               if (s_q[0]) p_q <= p_q + mc_q;
               s_q   <= s_q >> 1;
               mc_q  <= mc_q << 1;
               cnt_q <= cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) state <= DONE;
            end
            DONE: begin
               state       <= IDLE;
               computing_q <= 1'b0;
               finish_q    <= 1'b1;
               res_q       <= res_nxt;
               special_q   <= sc_nxt;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.res          = res_q;
   assign bus.finish       = finish_q;
   assign bus.computing    = computing_q;
   assign bus.special_case = special_q;
   assign dbg_state        = state;
endmodule

// File: tb/tb_fphub_square.sv
// Directed bench for fphub_square (M=23, E=8): vector table plus hand-written reset,
// ignored-start and back-to-back sequences.
module tb_fphub_square;
   localparam int M    = 23;
   localparam int E    = 8;
   localparam int T    = M + E;
   localparam int LAT  = M + 3;
   localparam int SLAT = 2;
   localparam int NV   = 17;

   logic       clk = 1'b0;
   logic       rst_l = 1'b0;
   logic [1:0] dbg_state;
   int         n_vec = 0;
   int         n_err = 0;

   fphub_square_if #(.M(M), .E(E)) bus ();

   fphub_square #(.M(M), .E(E)) dut (
      .clk       (clk),
      .rst_l     (rst_l),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [T:0] x;
      logic [T:0] res;
      logic       sc;
      logic [7:0] lat;
   } vec_t;

   vec_t vecs [NV];

   task automatic check(input string name, input logic [T:0] act, input logic [T:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Present x with start for one edge, then scramble x to show it was captured.
   task automatic do_accept(input logic [T:0] xv);
      bus.start = 1'b1;
      bus.x     = xv;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.x     = $urandom;
   endtask

   task automatic wait_finish(input string name, input logic [T:0] exp_res,
                              input logic exp_sc, input int exp_lat);
      int   cyc   = 0;
      logic got   = 1'b0;
      logic quiet = 1'b1;
      logic busy  = 1'b1;
      while (!got && cyc < 40) begin
         @(posedge clk);
         #1;
         cyc++;
         if (bus.finish) got = 1'b1;
         else begin
            if (bus.res != '0 || bus.special_case) quiet = 1'b0;
            if (!bus.computing) busy = 1'b0;
         end
      end
      check({name, "_finished"}, (T+1)'(got), (T+1)'(1));
      check({name, "_latency"}, (T+1)'(cyc), (T+1)'(exp_lat));
      check({name, "_res"}, bus.res, exp_res);
      check({name, "_special"}, (T+1)'(bus.special_case), (T+1)'(exp_sc));
      check({name, "_idle_at_finish"}, (T+1)'(bus.computing), (T+1)'(0));
      check({name, "_quiet_and_busy"}, (T+1)'({quiet, busy}), (T+1)'(3));
   endtask

   task automatic expect_no_finish(input string name, input int ncyc);
      logic seen = 1'b0;
      for (int i = 0; i < ncyc; i++) begin
         @(posedge clk);
         #1;
         if (bus.finish || bus.computing) seen = 1'b1;
      end
      check({name, "_no_finish"}, (T+1)'(seen), (T+1)'(0));
   endtask

   task automatic check_outputs_zero(input string name);
      check({name, "_res"}, bus.res, '0);
      check({name, "_flags"}, (T+1)'({bus.finish, bus.computing, bus.special_case}), '0);
      check({name, "_state"}, (T+1)'(dbg_state), '0);
   endtask

   initial begin
      // {x, expected res, expected special_case, finish latency in cycles}
      vecs[0]  = '{32'h3F800000, 32'h3F800001, 1'b0, 8'(LAT)};
      vecs[1]  = '{32'h3FFFFFFF, 32'h407FFFFF, 1'b0, 8'(LAT)};
      vecs[2]  = '{32'hC0000000, 32'h40800001, 1'b0, 8'(LAT)};
      vecs[3]  = '{32'h40000000, 32'h40800001, 1'b0, 8'(LAT)};
      vecs[4]  = '{32'h3FC00000, 32'h40100000, 1'b0, 8'(LAT)};
      vecs[5]  = '{32'h7F000000, 32'h7FFFFFFF, 1'b1, 8'(LAT)};
      vecs[6]  = '{32'h00800000, 32'h00000000, 1'b1, 8'(LAT)};
      vecs[7]  = '{32'h5F800000, 32'h7FFFFFFF, 1'b1, 8'(LAT)};
      vecs[8]  = '{32'h5F7FFFFF, 32'h7F7FFFFF, 1'b0, 8'(LAT)};
      vecs[9]  = '{32'h1FFFFFFF, 32'h00000000, 1'b1, 8'(LAT)};
      vecs[10] = '{32'h20000000, 32'h00800001, 1'b0, 8'(LAT)};
      vecs[11] = '{32'h00000000, 32'h00000000, 1'b1, 8'(SLAT)};
      vecs[12] = '{32'h7F800000, 32'h7FFFFFFF, 1'b1, 8'(SLAT)};
      vecs[13] = '{32'h80000000, 32'h00000000, 1'b1, 8'(SLAT)};
      vecs[14] = '{32'hFF800000, 32'h7FFFFFFF, 1'b1, 8'(SLAT)};
      vecs[15] = '{32'h007FFFFF, 32'h00000000, 1'b1, 8'(SLAT)};
      vecs[16] = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 8'(SLAT)};

      bus.start = 1'b0;
      bus.x     = '0;
      #1;
      check_outputs_zero("reset");
      repeat (3) @(posedge clk);
      #1;
      rst_l = 1'b1;
      @(posedge clk);
      #1;
      check_outputs_zero("post_reset_idle");

      for (int i = 0; i < NV; i++) begin
         do_accept(vecs[i].x);
         wait_finish($sformatf("v%0d", i), vecs[i].res, vecs[i].sc, int'(vecs[i].lat));
         @(posedge clk);
         #1;
         check($sformatf("v%0d_pulse_ends", i), (T+1)'({bus.finish, bus.special_case}), '0);
         check($sformatf("v%0d_res_cleared", i), bus.res, '0);
      end

      // Start pulsed mid-computation must not disturb the running operation.
      do_accept(32'h3F800000);
      repeat (5) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.x     = 32'h7F800000;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_finish("ignored_start", 32'h3F800001, 1'b0, LAT - 6);
      expect_no_finish("ignored_start_after", 4);

      // Start held in the finish cycle launches the next operation.
      do_accept(32'h3F800000);
      wait_finish("b2b_first", 32'h3F800001, 1'b0, LAT);
      do_accept(32'h40000000);
      wait_finish("b2b_second", 32'h40800001, 1'b0, LAT);
      do_accept(32'h00000000);
      wait_finish("b2b_special", 32'h00000000, 1'b1, SLAT);

      // Asynchronous reset in the middle of the iterations.
      do_accept(32'h3FFFFFFF);
      repeat (10) @(posedge clk);
      #1;
      check("mid_op_busy", (T+1)'(bus.computing), (T+1)'(1));
      #2;
      rst_l = 1'b0;
      #1;
      check_outputs_zero("mid_op_reset");
      @(posedge clk);
      #1;
      rst_l = 1'b1;
      expect_no_finish("aborted_op", 40);
      do_accept(32'h3FFFFFFF);
      wait_finish("after_reset", 32'h407FFFFF, 1'b0, LAT);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
